priority_encoder: RTL and testbench



---
 rtl/priority_encoder.sv | 69 ++++++
 tb/tb_priority_encoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder.sv
// 8-to-3 priority encoder with a sticky pending set and a one-deep output slot.
// The highest pending index is presented when the slot is free; duplicates set overflow.
module priority_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       out_ready,
  input  logic       clr_ovf,
  output logic       out_valid,
  output logic [2:0] out_code,
  output logic [7:0] pending,
  output logic       overflow
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state;
  logic       slot_free;
  logic       load;
  logic [2:0] top_code;
  logic [7:0] load_mask;
  logic [7:0] pending_next;
  logic       dup;

  assign out_valid = (state == PRESENT);

  // Ascending scan so the last assignment (highest set index) wins.
  always_comb begin
    top_code = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (pending[i]) top_code = 3'(i);
    end
  end

  always_comb begin
    slot_free    = !out_valid || out_ready;
    load         = slot_free && (pending != '0);
    load_mask    = load ? (8'd1 << top_code) : '0;
    pending_next = (pending & ~load_mask) | req;
    dup          = |(req & pending & ~load_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      out_code <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= pending_next;
      if (dup)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
      if (slot_free) begin
        if (load) begin
          state    <= PRESENT;
          out_code <= top_code;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_priority_encoder.sv
// Directed-vector bench for priority_encoder; expected values are hand-computed.
module tb_priority_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       out_ready;
  logic       clr_ovf;
  logic       out_valid;
  logic [2:0] out_code;
  logic [7:0] pending;
  logic       overflow;

  int unsigned n_cmp;
  int unsigned n_bad;

  priority_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .out_ready(out_ready),
    .clr_ovf  (clr_ovf),
    .out_valid(out_valid),
    .out_code (out_code),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before checks/drives.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [2:0] c,
                            input logic [7:0] p);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) check({tag, ".code"}, 32'(out_code), 32'(c));
    check({tag, ".pending"}, 32'(pending), 32'(p));
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    req       = 8'hFF;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;

    // Reset, with requests present that must be ignored
    step();
    step();
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.code", 32'(out_code), 32'd0);
    check("rst.pending", 32'(pending), 32'd0);
    check("rst.overflow", 32'(overflow), 32'd0);
    req   = 8'h00;
    rst_n = 1'b1;
    step();
    expect_out("rst.post", 1'b0, 3'd0, 8'h00);

    // Single request, two-cycle latency
    out_ready = 1'b1;
    req       = 8'h04;
    step();
    req = 8'h00;
    expect_out("single.e1", 1'b0, 3'd0, 8'h04);
    step();
    expect_out("single.e2", 1'b1, 3'd2, 8'h00);
    step();
    expect_out("single.e3", 1'b0, 3'd0, 8'h00);
    check("single.hold", 32'(out_code), 32'd2);

    // Priority order, one code per cycle
    req = 8'hA5;
    step();
    req = 8'h00;
    expect_out("prio.e1", 1'b0, 3'd0, 8'hA5);
    step();
    expect_out("prio.c7", 1'b1, 3'd7, 8'h25);
    step();
    expect_out("prio.c5", 1'b1, 3'd5, 8'h05);
    step();
    expect_out("prio.c2", 1'b1, 3'd2, 8'h01);
    step();
    expect_out("prio.c0", 1'b1, 3'd0, 8'h00);
    step();
    expect_out("prio.idle", 1'b0, 3'd0, 8'h00);

    // Backpressure
    out_ready = 1'b0;
    req       = 8'h81;
    step();
    req = 8'h00;
    expect_out("bp.e1", 1'b0, 3'd0, 8'h81);
    step();
    expect_out("bp.c7", 1'b1, 3'd7, 8'h01);
    step();
    expect_out("bp.hold7", 1'b1, 3'd7, 8'h01);
    step();
    expect_out("bp.hold7b", 1'b1, 3'd7, 8'h01);
    out_ready = 1'b1;
    step();
    expect_out("bp.c0", 1'b1, 3'd0, 8'h00);
    step();
    expect_out("bp.idle", 1'b0, 3'd0, 8'h00);
    check("bp.noovf", 32'(overflow), 32'd0);

    // Overflow: keep code 7 stalled so pending[3] cannot drain
    out_ready = 1'b0;
    req       = 8'h88;
    step();
    req = 8'h00;
    step();
    expect_out("ovf.c7", 1'b1, 3'd7, 8'h08);
    check("ovf.pre", 32'(overflow), 32'd0);
    req = 8'h08;
    step();
    check("ovf.set", 32'(overflow), 32'd1);
    expect_out("ovf.dup1", 1'b1, 3'd7, 8'h08);
    clr_ovf = 1'b1;  // second duplicate with clear: set wins
    step();
    check("ovf.setwins", 32'(overflow), 32'd1);
    req       = 8'h00;
    clr_ovf   = 1'b0;
    out_ready = 1'b1;
    step();
    expect_out("ovf.c3", 1'b1, 3'd3, 8'h00);
    step();
    expect_out("ovf.once", 1'b0, 3'd0, 8'h00);
    check("ovf.sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf.clr", 32'(overflow), 32'd0);

    // Re-request in the cycle code 4 is accepted
    req = 8'h10;
    step();
    req = 8'h00;
    step();
    expect_out("rereq.c4", 1'b1, 3'd4, 8'h00);
    req = 8'h10;
    step();
    req = 8'h00;
    expect_out("rereq.q", 1'b0, 3'd0, 8'h10);
    check("rereq.noovf", 32'(overflow), 32'd0);
    step();
    expect_out("rereq.c4b", 1'b1, 3'd4, 8'h00);
    step();
    expect_out("rereq.idle", 1'b0, 3'd0, 8'h00);

    // Async reset mid-cycle with work outstanding
    out_ready = 1'b0;
    req       = 8'hF0;
    step();
    step();
    expect_out("arst.pre", 1'b1, 3'd7, 8'hF0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(out_valid), 32'd0);
    check("arst.code", 32'(out_code), 32'd0);
    check("arst.pending", 32'(pending), 32'd0);
    check("arst.overflow", 32'(overflow), 32'd0);
    step();
    check("arst.ignreq", 32'(pending), 32'd0);
    req       = 8'h00;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("arst.after", 1'b0, 3'd0, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
